// File: rtl/mic1_phase_sequencer.sv
// MIC-1 four-subcycle microcycle sequencer: one-hot phase strobes, run/halt control, and memory-wait stretching.
// Optional single-step control is compiled in when SINGLE_STEP_EN is defined.
module mic1_phase_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_req,
  input  logic             step,
  input  logic             mem_busy,
  output logic [3:0]       phase,
  output logic             cycle_done,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_HALT, S_SUB1, S_SUB2, S_SUB3, S_SUB4, S_WAIT
  } state_t;

  state_t state, state_nx;
  logic   halt_pend, halt_pend_nx;
  logic   step_pend, step_pend_nx;
  logic   step_go;

`ifdef SINGLE_STEP_EN
  assign step_go = step & ~start & ~halt_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_pend <= 1'b0;
    else       step_pend <= step_pend_nx;
  end
`else
  logic unused_step;
  assign unused_step = step;
  assign step_go     = 1'b0;
  assign step_pend   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_HALT;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_nx;
      halt_pend <= halt_pend_nx;
    end
  end

  // Subcycle 4 and its stretched WAIT form share the same strobe.
  always_comb begin
    phase = 4'b0000;
    case (state)
      S_SUB1:         phase = 4'b0001;
      S_SUB2:         phase = 4'b0010;
      S_SUB3:         phase = 4'b0100;
      S_SUB4, S_WAIT: phase = 4'b1000;
      default:        phase = 4'b0000;
    endcase
  end

  assign running    = (state != S_HALT);
  assign cycle_done = phase[3] & ~mem_busy;

  always_comb begin
    state_nx     = state;
    halt_pend_nx = halt_pend;
    step_pend_nx = step_pend;
    if (running && halt_req) halt_pend_nx = 1'b1;
    case (state)
      S_HALT: begin
        if (start && !halt_req) begin
          state_nx = S_SUB1;
        end else if (step_go) begin
          state_nx     = S_SUB1;
          step_pend_nx = 1'b1;
        end
      end
      S_SUB1: state_nx = S_SUB2;
      S_SUB2: state_nx = S_SUB3;
      S_SUB3: state_nx = S_SUB4;
      S_SUB4, S_WAIT: begin
        if (mem_busy) begin
          state_nx = S_WAIT;
        end else begin
          // A halt_req arriving on the completing edge still stops here.
          if (halt_pend || halt_req || step_pend) state_nx = S_HALT;
          else                                    state_nx = S_SUB1;
          halt_pend_nx = 1'b0;
          step_pend_nx = 1'b0;
        end
      end
      default: state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           cycle_count <= '0;
    else if (cycle_done) cycle_count <= cycle_count + 1'b1;
  end

endmodule

// File: tb/tb_mic1_phase_sequencer.sv
// Directed bench for mic1_phase_sequencer (CNT_W=4 so counter wrap is reachable quickly).
module tb_mic1_phase_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, start, halt_req, step, mem_busy;
  logic [3:0]       phase;
  logic             cycle_done, running;
  logic [CNT_W-1:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  mic1_phase_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .step(step),
    .mem_busy(mem_busy), .phase(phase), .cycle_done(cycle_done), .running(running),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one clock of inputs, check outputs mid-cycle, then advance past the edge.
  task automatic clk1(input string tag, input logic st, input logic hr, input logic sp,
                      input logic mb, input logic [3:0] eph, input logic edone);
    start = st; halt_req = hr; step = sp; mem_busy = mb;
    #1;
    chk({tag, ".phase"}, 32'(phase), 32'(eph));
    chk({tag, ".done"},  32'(cycle_done), 32'(edone));
    chk({tag, ".run"},   32'(running), 32'(eph != 4'b0000));
    chk({tag, ".cnt"},   32'(cycle_count), 32'(exp_cnt));
    @(posedge clk); #1;
    if (edone) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    start = 1'b0; halt_req = 1'b0; step = 1'b0;
  endtask

  task automatic micro(input string tag, input logic hr_at1);
    clk1(tag, 1'b0, hr_at1, 1'b0, 1'b0, 4'b0001, 1'b0);
    clk1(tag, 1'b0, 1'b0,   1'b0, 1'b0, 4'b0010, 1'b0);
    clk1(tag, 1'b0, 1'b0,   1'b0, 1'b0, 4'b0100, 1'b0);
    clk1(tag, 1'b0, 1'b0,   1'b0, 1'b0, 4'b1000, 1'b1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; step = 1'b0; mem_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.phase", 32'(phase), 32'h0);
    chk("rst.run",   32'(running), 32'h0);
    chk("rst.cnt",   32'(cycle_count), 32'h0);
    reset = 1'b0;

    // 1: async reset mid-subcycle 3 of the second microcycle
    clk1("t1.go", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    micro("t1.m1", 1'b0);
    clk1("t1.s1", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    clk1("t1.s2", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
    chk("t1.pre_ph", 32'(phase), 32'h4);
    #2 reset = 1'b1;
    #1;
    chk("t1.async_ph",  32'(phase), 32'h0);
    chk("t1.async_run", 32'(running), 32'h0);
    chk("t1.async_cnt", 32'(cycle_count), 32'h0);
    exp_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;

    // 2: free run three microcycles
    clk1("t2.go", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) micro("t2.run", 1'b0);
    chk("t2.cnt3", 32'(cycle_count), 32'd3);

    // 3: memory wait stretches subcycle 4 to six clocks
    clk1("t3.s1", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0);
    clk1("t3.s2", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0);
    clk1("t3.s3", 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100, 1'b0);
    for (int i = 0; i < 5; i++) clk1("t3.wait", 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 1'b0);
    clk1("t3.end", 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1);
    chk("t3.cnt4", 32'(cycle_count), 32'd4);

    // 4: halt_req in subcycle 2 completes the microcycle then halts
    clk1("t4.s1", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
    clk1("t4.s2", 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0);
    clk1("t4.s3", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0);
    clk1("t4.s4", 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 1'b1);
    clk1("t4.hlt", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("t4.cnt5", 32'(cycle_count), 32'd5);
    clk1("t4.both", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    clk1("t4.stay", 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
    clk1("t4.stay2", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);

    // 5: single step
    clk1("t5.step", 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
`ifdef SINGLE_STEP_EN
    micro("t5.m", 1'b0);
    clk1("t5.hlt", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("t5.cnt6", 32'(cycle_count), 32'd6);
`else
    for (int i = 0; i < 5; i++) clk1("t5.idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("t5.cnt5", 32'(cycle_count), 32'd5);
`endif

    // 6: run until the counter reaches all-ones, then one more wraps it to 0 and halts
    clk1("t6.go", 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    while (exp_cnt != 15) micro("t6.run", 1'b0);
    chk("t6.full", 32'(cycle_count), 32'hF);
    micro("t6.last", 1'b1);
    clk1("t6.hlt", 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    chk("t6.wrap", 32'(cycle_count), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
